// File: rtl/pe_dbw_if.sv
// Bus bundle for one pe_dbw processing element: west/north data in, east/south data out,
// and the north-to-south weight-load chain. The master drives the PE, the slave is the PE.
interface pe_dbw_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] input_in;
  logic [DATA_WIDTH-1:0] psum_in;
  logic [DATA_WIDTH-1:0] weight_in;
  logic                  weight_load;
  logic                  weight_swap;

  logic                  valid_out;
  logic [DATA_WIDTH-1:0] input_out;
  logic [DATA_WIDTH-1:0] psum_out;
  logic [DATA_WIDTH-1:0] weight_out;
  logic                  ovf_out;

  modport master (
    output valid_in, input_in, psum_in, weight_in, weight_load, weight_swap,
    input  valid_out, input_out, psum_out, weight_out, ovf_out
  );

  modport slave (
    input  valid_in, input_in, psum_in, weight_in, weight_load, weight_swap,
    output valid_out, input_out, psum_out, weight_out, ovf_out
  );
endinterface

// File: rtl/pe_dbw.sv
// Weight-stationary systolic PE with double-buffered weight: psum_out = psum_in + input_in * active.
// Define PE_SATURATE_EN to clamp on overflow; otherwise results wrap. ovf_out flags either case.
module pe_dbw #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  pe_dbw_if.slave     bus
);

`ifdef PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  valid_q,  valid_d;
  logic [DATA_WIDTH-1:0] input_q,  input_d;
  logic [DATA_WIDTH-1:0] psum_q,   psum_d;
  logic                  ovf_q,    ovf_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] active_q, active_d;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [2*DATA_WIDTH-1:0] shifted;
  logic                           fits_prod;
  logic        [DATA_WIDTH-1:0]   red_prod;
  logic        [DATA_WIDTH:0]     sum;
  logic                           fits_sum;
  logic        [DATA_WIDTH-1:0]   red_sum;

  always_comb begin
    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    prod    = $signed(bus.input_in) * $signed(active_q);
    shifted = prod >>> FRAC_BITS;

    // The shifted product fits when its top DATA_WIDTH+1 bits are all copies of the sign.
    fits_prod = (shifted[2*DATA_WIDTH-1:DATA_WIDTH-1] == '0) ||
                (shifted[2*DATA_WIDTH-1:DATA_WIDTH-1] == '1);
    if (fits_prod || !SAT) begin
      red_prod = shifted[DATA_WIDTH-1:0];
    end else begin
      red_prod = shifted[2*DATA_WIDTH-1] ? MIN_VAL : MAX_VAL;
    end

    sum      = {bus.psum_in[DATA_WIDTH-1], bus.psum_in} + {red_prod[DATA_WIDTH-1], red_prod};
    fits_sum = (sum[DATA_WIDTH] == sum[DATA_WIDTH-1]);
    if (fits_sum || !SAT) begin
      red_sum = sum[DATA_WIDTH-1:0];
    end else begin
      red_sum = sum[DATA_WIDTH] ? MIN_VAL : MAX_VAL;
    end

    valid_d = bus.valid_in;
    input_d = bus.valid_in ? bus.input_in : '0;
    psum_d  = bus.valid_in ? red_sum : '0;
    ovf_d   = bus.valid_in && (!fits_prod || !fits_sum);

    // Swap reads shadow_q, the pre-edge value, so load+swap together hands over the old shadow.
    shadow_d = bus.weight_load ? bus.weight_in : shadow_q;
    active_d = bus.weight_swap ? shadow_q : active_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values of its peers.
    if (rst) begin
      valid_q  <= 1'b0;
      input_q  <= '0;
      psum_q   <= '0;
      ovf_q    <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      valid_q  <= valid_d;
      input_q  <= input_d;
      psum_q   <= psum_d;
      ovf_q    <= ovf_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign bus.valid_out  = valid_q;
  assign bus.input_out  = input_q;
  assign bus.psum_out   = psum_q;
  assign bus.ovf_out    = ovf_q;
  assign bus.weight_out = shadow_q;

endmodule

// File: tb/tb_pe_dbw.sv
// Self-checking bench for pe_dbw (Q8.8): directed vector table, hand-written weight-swap and
// bubble sequences, then randomized traffic against an integer-arithmetic reference model.
module tb_pe_dbw;

  localparam int W = 16;
  localparam int F = 8;

`ifdef PE_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  pe_dbw_if #(.DATA_WIDTH(W)) bus ();

  pe_dbw #(.DATA_WIDTH(W), .FRAC_BITS(F)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.valid_in    = 1'b0;
    bus.input_in    = '0;
    bus.psum_in     = '0;
    bus.weight_in   = '0;
    bus.weight_load = 1'b0;
    bus.weight_swap = 1'b0;
  endtask

  task automatic set_active(input logic [W-1:0] w);
    idle_inputs();
    bus.weight_in   = w;
    bus.weight_load = 1'b1;
    step();
    bus.weight_load = 1'b0;
    bus.weight_swap = 1'b1;
    step();
    bus.weight_swap = 1'b0;
  endtask

  // Reference model: exact integer arithmetic, floor shift, then clamp or modular wrap.
  function automatic longint reduce(input longint x, output bit lost);
    longint lo, hi, m, y;
    lo = -(longint'(1) <<< (W-1));
    hi =  (longint'(1) <<< (W-1)) - 1;
    m  =  longint'(1) <<< W;
    lost = (x < lo) || (x > hi);
    if (!lost) return x;
    if (SAT) return (x < lo) ? lo : hi;
    y = ((x % m) + m) % m;
    if (y > hi) y -= m;
    return y;
  endfunction

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] w,
                                input logic [W-1:0] p, output logic [W-1:0] r,
                                output bit ovf);
    longint prod, t1, t2;
    bit l1, l2;
    prod = longint'($signed(a)) * longint'($signed(w));
    t1   = reduce(prod >>> F, l1);
    t2   = reduce(longint'($signed(p)) + t1, l2);
    r    = t2[W-1:0];
    ovf  = l1 | l2;
  endfunction

  typedef struct {
    string      name;
    logic [W-1:0] w, a, p, exp_psum;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[7];

  logic [W-1:0] m_shadow, m_active, e_psum;
  bit           e_ovf;

  initial begin
    vecs[0] = '{"basic_mac",   16'h0200, 16'h0180, 16'h0100, 16'h0400, 1'b0};
    vecs[1] = '{"neg_trunc",   16'hFF80, 16'h0001, 16'h0000, 16'hFFFF, 1'b0};
    vecs[2] = '{"normal_half", 16'h0080, 16'h0300, 16'h0050, 16'h01D0, 1'b0};
`ifdef PE_SATURATE_EN
    vecs[3] = '{"prod_ovf_pos", 16'h0200, 16'h7000, 16'h0000, 16'h7FFF, 1'b1};
    vecs[4] = '{"prod_ovf_neg", 16'hFE00, 16'h7000, 16'h0000, 16'h8000, 1'b1};
    vecs[5] = '{"sum_ovf_pos",  16'h0100, 16'h7000, 16'h2000, 16'h7FFF, 1'b1};
    vecs[6] = '{"sum_ovf_neg",  16'h0100, 16'h8000, 16'hFFFF, 16'h8000, 1'b1};
`else
    vecs[3] = '{"prod_ovf_pos", 16'h0200, 16'h7000, 16'h0000, 16'hE000, 1'b1};
    vecs[4] = '{"prod_ovf_neg", 16'hFE00, 16'h7000, 16'h0000, 16'h2000, 1'b1};
    vecs[5] = '{"sum_ovf_pos",  16'h0100, 16'h7000, 16'h2000, 16'h9000, 1'b1};
    vecs[6] = '{"sum_ovf_neg",  16'h0100, 16'h8000, 16'hFFFF, 16'h7FFF, 1'b1};
`endif

    // Reset with every input nonzero.
    rst             = 1'b1;
    bus.valid_in    = 1'b1;
    bus.input_in    = 16'h1234;
    bus.psum_in     = 16'h5678;
    bus.weight_in   = 16'h9ABC;
    bus.weight_load = 1'b1;
    bus.weight_swap = 1'b1;
    step();
    step();
    check("rst_valid",  bus.valid_out,  0);
    check("rst_input",  bus.input_out,  0);
    check("rst_psum",   bus.psum_out,   0);
    check("rst_weight", bus.weight_out, 0);
    check("rst_ovf",    bus.ovf_out,    0);
    rst = 1'b0;
    idle_inputs();
    step();
    check("post_rst_valid",  bus.valid_out,  0);
    check("post_rst_psum",   bus.psum_out,   0);
    check("post_rst_weight", bus.weight_out, 0);
    // Active weight reset to 0: result is just psum_in.
    bus.valid_in = 1'b1;
    bus.input_in = 16'h0100;
    bus.psum_in  = 16'h0005;
    step();
    check("rst_active_zero", bus.psum_out, 16'h0005);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      set_active(vecs[i].w);
      check({vecs[i].name, "_wout"}, bus.weight_out, vecs[i].w);
      bus.valid_in = 1'b1;
      bus.input_in = vecs[i].a;
      bus.psum_in  = vecs[i].p;
      step();
      check({vecs[i].name, "_psum"},  bus.psum_out,  vecs[i].exp_psum);
      check({vecs[i].name, "_input"}, bus.input_out, vecs[i].a);
      check({vecs[i].name, "_valid"}, bus.valid_out, 1);
      check({vecs[i].name, "_ovf"},   bus.ovf_out,   vecs[i].exp_ovf);
    end

    // Overlapped load: compute continues while the next weight is shifted in.
    set_active(16'h0100);
    bus.valid_in    = 1'b1;
    bus.input_in    = 16'h0100;
    bus.psum_in     = 16'h0000;
    bus.weight_in   = 16'h0300;
    bus.weight_load = 1'b1;
    step();
    check("ovl_during_load", bus.psum_out, 16'h0100);
    check("ovl_shadow",      bus.weight_out, 16'h0300);
    bus.weight_load = 1'b0;
    bus.weight_swap = 1'b1;
    step();
    check("ovl_swap_cycle", bus.psum_out, 16'h0100);
    bus.weight_swap = 1'b0;
    step();
    check("ovl_after_swap", bus.psum_out, 16'h0300);

    // Simultaneous load+swap: active takes the old shadow.
    bus.weight_in   = 16'h0500;
    bus.weight_load = 1'b1;
    step();
    bus.weight_in   = 16'h0700;
    bus.weight_swap = 1'b1;
    step();
    check("ls_old_active", bus.psum_out,   16'h0300);
    check("ls_new_shadow", bus.weight_out, 16'h0700);
    bus.weight_load = 1'b0;
    bus.weight_swap = 1'b0;
    step();
    check("ls_active_old_shadow", bus.psum_out,   16'h0500);
    check("ls_shadow_hold",       bus.weight_out, 16'h0700);

    // Bubble: valid 1,0,1 with active = 0x0500.
    bus.input_in = 16'h0100;
    bus.psum_in  = 16'h0010;
    bus.valid_in = 1'b1;
    step();
    check("bub0_valid", bus.valid_out, 1);
    check("bub0_psum",  bus.psum_out,  16'h0510);
    bus.valid_in = 1'b0;
    step();
    check("bub1_valid", bus.valid_out, 0);
    check("bub1_psum",  bus.psum_out,  0);
    check("bub1_input", bus.input_out, 0);
    bus.valid_in = 1'b1;
    step();
    check("bub2_valid", bus.valid_out, 1);
    check("bub2_psum",  bus.psum_out,  16'h0510);

    // Randomized traffic against the model, with occasional reset.
    m_shadow = 16'h0700;
    m_active = 16'h0500;
    for (int c = 0; c < 400; c++) begin
      logic do_rst;
      do_rst          = ($urandom_range(0, 31) == 0);
      rst             = do_rst;
      bus.valid_in    = $urandom_range(0, 3) != 0;
      bus.input_in    = W'($urandom);
      bus.psum_in     = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 255));
      bus.weight_in   = ($urandom_range(0, 1) != 0) ? W'($urandom) : W'($urandom_range(0, 16'h0400));
      bus.weight_load = $urandom_range(0, 3) == 0;
      bus.weight_swap = $urandom_range(0, 5) == 0;
      if (do_rst) begin
        e_psum   = '0;
        e_ovf    = 1'b0;
        m_shadow = '0;
        m_active = '0;
        step();
        check("rnd_rst_psum",   bus.psum_out,   0);
        check("rnd_rst_valid",  bus.valid_out,  0);
        check("rnd_rst_weight", bus.weight_out, 0);
      end else begin
        model(bus.input_in, m_active, bus.psum_in, e_psum, e_ovf);
        if (!bus.valid_in) begin
          e_psum = '0;
          e_ovf  = 1'b0;
        end
        if (bus.weight_swap) m_active = m_shadow;
        if (bus.weight_load) m_shadow = bus.weight_in;
        begin
          logic [W-1:0] exp_in;
          logic         exp_v;
          exp_in = bus.valid_in ? bus.input_in : '0;
          exp_v  = bus.valid_in;
          step();
          check("rnd_psum",   bus.psum_out,   e_psum);
          check("rnd_ovf",    bus.ovf_out,    e_ovf);
          check("rnd_valid",  bus.valid_out,  exp_v);
          check("rnd_input",  bus.input_out,  exp_in);
          check("rnd_weight", bus.weight_out, m_shadow);
        end
      end
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pe_dbw.md
Name: pe_dbw

Overview:
- Parametrised weight-stationary systolic processing element; successor to the fixed 16-bit PE.
- Computes psum_out = psum_in + input_in * active weight in signed fixed point, and forwards input_in east.
- Adds a double-buffered (shadow/active) weight with a north-to-south weight-load chain, so the next weight set loads while the array keeps computing.
- Adds a registered overflow indicator and configurable width and fraction bits.

Parameters:
- DATA_WIDTH, 16, width of all data, psum and weight ports; signed two's complement.
- FRAC_BITS, 8, fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS); legal range 0..DATA_WIDTH-1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- valid_in  in  1  input_in/psum_in valid this cycle.
- valid_out  out  1  input_out/psum_out valid.
- input_in  in  DATA_WIDTH  activation from west neighbour.
- psum_in  in  DATA_WIDTH  partial sum from north neighbour.
- input_out  out  DATA_WIDTH  registered activation to east neighbour.
- psum_out  out  DATA_WIDTH  registered partial sum to south neighbour.
- weight_in  in  DATA_WIDTH  weight from north neighbour's load chain.
- weight_load  in  1  shift weight_in into shadow register.
- weight_swap  in  1  copy shadow register into active weight.
- weight_out  out  DATA_WIDTH  shadow register value, feeds south neighbour's weight_in.
- ovf_out  out  1  registered: arithmetic overflow occurred in the result now on psum_out.

Behaviour:
- Reset (rst=1 at edge): valid_out, input_out, psum_out, weight_out (shadow), active weight and ovf_out all become 0. Reset overrides all other inputs. Reset mid-load or mid-compute discards all in-flight data.
- Datapath latency is 1 cycle.
  - If valid_in=1 at edge N: after edge N, input_out=input_in, psum_out=result, valid_out=1, ovf_out=overflow flag.
  - If valid_in=0: valid_out<=0, psum_out<=0, ovf_out<=0, input_out<=0.
- Arithmetic:
  - Full product is 2*DATA_WIDTH signed.
  - Product is arithmetically shifted right by FRAC_BITS (truncation toward -inf).
  - Product is reduced to DATA_WIDTH: saturate or wrap, per the optional feature.
  - The reduced product is added to psum_in at DATA_WIDTH+1 bits, then reduced to DATA_WIDTH by the same rule.
  - Overflow flag = either reduction step lost information.
- Weight path, independent of valid_in; compute never stalls during loading:
  - weight_load=1: shadow<=weight_in. Otherwise shadow holds.
  - weight_swap=1: active<=shadow (the value before this edge). Otherwise active holds.
  - Both asserted in the same cycle: active gets the old shadow and shadow gets weight_in.
  - A compute in the same cycle as a swap uses the old active weight. The new weight applies from the next cycle.
- Column loading: asserting weight_load for K consecutive cycles on a K-deep column shifts K weights down. The first-fed value ends in the bottom PE.

Optional Feature:
- Macro PE_SATURATE_EN.
- Defined: both reductions clamp to max (0111..1) or min (1000..0) signed value; ovf_out reflects any clamping.
- Undefined: both reductions keep the low DATA_WIDTH bits (wrap); ovf_out still reports that wrap occurred.
- Normal (non-overflowing) results are identical in both builds.

Test Plan:
- Reset: drive rst=1 for 2 cycles with all inputs nonzero -> every output 0. Then release with valid_in=0 -> outputs stay 0.
- Basic MAC (Q8.8): load shadow=0x0200 (2.0), swap, then valid_in=1, input_in=0x0180 (1.5), psum_in=0x0100 (1.0) -> next cycle psum_out=0x0400, input_out=0x0180, valid_out=1, ovf_out=0.
- Negative/truncation: active=0xFF80 (-0.5), input_in=0x0001, psum_in=0 -> psum_out=0xFFFF (floor of -1/512 in Q8.8), ovf_out=0.
- Overlapped load: active=0x0100. Load shadow=0x0300 while streaming input_in=0x0100 each cycle with psum_in=0 -> psum_out=0x0100 until the swap cycle inclusive, 0x0300 afterward. Simultaneous load+swap puts the old shadow in active.
- Overflow: active=0x0200, input_in=0x7000, psum_in=0 -> with PE_SATURATE_EN psum_out=0x7FFF, ovf_out=1. Without it psum_out=0xE000, ovf_out=1.
- Bubble: valid_in pattern 1,0,1 -> valid_out 1,0,1 one cycle later, with psum_out=0 in the gap cycle.
